// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the two-player scoreboard: score width and limit,
// pending-op encoding and display scheduler state encoding.
package scoreboard_pkg;

  localparam int SCORE_W   = 7;
  localparam int MAX_SCORE = 99;

  typedef enum logic {
    OP_UP   = 1'b0,
    OP_DOWN = 1'b1
  } op_e;

  typedef enum logic {
    ST_ROTATE = 1'b0,
    ST_HOLD   = 1'b1
  } disp_state_e;

  typedef struct packed {
    logic valid;
    op_e  op;
  } slot_t;

  // Saturating step: UP stops at MAX_SCORE, DOWN stops at 0.
  function automatic logic [SCORE_W-1:0] apply_op(input logic [SCORE_W-1:0] score,
                                                  input op_e                op);
    logic [SCORE_W-1:0] result;
    result = score;
    if (op == OP_UP) begin
      if (score != SCORE_W'(MAX_SCORE)) result = score + SCORE_W'(1);
    end else begin
      if (score != '0) result = score - SCORE_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/display_scheduler.sv
// Chooses which player's score drives the shared 7-seg path: rotates between
// players on a fixed period, and holds a freshly updated player for a longer period.
module display_scheduler
  import scoreboard_pkg::*;
#(
  parameter int SWAP_TICKS = 2000,
  parameter int HOLD_TICKS = 3000
) (
  input  logic i_clk,
  input  logic i_rstN,
  input  logic i_update,
  input  logic i_updPlayer,
  output logic o_dispSel
);

  localparam int MAX_TICKS = (SWAP_TICKS > HOLD_TICKS) ? SWAP_TICKS : HOLD_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  disp_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dispSel;

  // An update always wins over the timer so that a new score is shown at once.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_state   <= ST_ROTATE;
      r_cnt     <= CNT_W'(SWAP_TICKS - 1);
      r_dispSel <= 1'b0;
    end else if (i_update) begin
      r_state   <= ST_HOLD;
      r_cnt     <= CNT_W'(HOLD_TICKS - 1);
      r_dispSel <= i_updPlayer;
    end else begin
      case (r_state)
        ST_ROTATE: begin
          if (r_cnt == '0) begin
            r_dispSel <= ~r_dispSel;
            r_cnt     <= CNT_W'(SWAP_TICKS - 1);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (r_cnt == '0) begin
            r_state <= ST_ROTATE;
            r_cnt   <= CNT_W'(SWAP_TICKS - 1);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_ROTATE;
          r_cnt   <= CNT_W'(SWAP_TICKS - 1);
        end
      endcase
    end
  end

  assign o_dispSel = r_dispSel;

endmodule

// File: rtl/score_arbiter.sv
// Two-player score keeper: one pending request slot per player, round-robin grant
// of one slot per cycle into saturating 0..99 scores, plus shared display selection.
module score_arbiter
  import scoreboard_pkg::*;
#(
  parameter int SWAP_TICKS = 2000,
  parameter int HOLD_TICKS = 3000
) (
  input  logic               clk_1khz_i,
  input  logic               rst_n_i,
  input  logic               up_a_i,
  input  logic               down_a_i,
  input  logic               up_b_i,
  input  logic               down_b_i,
  output logic [SCORE_W-1:0] score_a_o,
  output logic [SCORE_W-1:0] score_b_o,
  output logic [SCORE_W-1:0] disp_score_o,
  output logic               disp_sel_o,
  output logic               overflow_o
);

  // Index 0 is player A, index 1 is player B throughout.
  slot_t [1:0]              r_slot;
  logic  [1:0][SCORE_W-1:0] r_score;
  logic                     r_favorB;
  logic                     r_overflow;

  logic [1:0] w_up;
  logic [1:0] w_down;
  logic [1:0] w_req;
  op_e  [1:0] w_reqOp;
  logic [1:0] w_grant;
  logic [1:0] w_drop;
  logic       w_update;
  logic       w_dispSel;

  assign w_up   = {up_b_i, down_b_i & 1'b0 | up_b_i & 1'b0 | up_a_i} | {1'b0, 1'b0};
  assign w_down = {down_b_i, down_a_i};

  // Up and down together cancel out; a request into a busy slot is dropped unless
  // that slot is being drained on this same edge.
  always_comb begin
    w_req   = '0;
    w_reqOp = {OP_UP, OP_UP};
    w_drop  = '0;
    w_grant[0] = r_slot[0].valid & (~r_slot[1].valid | ~r_favorB);
    w_grant[1] = r_slot[1].valid & (~r_slot[0].valid |  r_favorB);
    for (int p = 0; p < 2; p++) begin
      w_req[p]   = w_up[p] ^ w_down[p];
      w_reqOp[p] = w_down[p] ? OP_DOWN : OP_UP;
      w_drop[p]  = w_req[p] & r_slot[p].valid & ~w_grant[p];
    end
  end

  assign w_update = |w_grant;

  always_ff @(posedge clk_1khz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_slot     <= '0;
      r_score    <= '0;
      r_favorB   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (w_req[p] && (!r_slot[p].valid || w_grant[p])) begin
          r_slot[p] <= slot_t'{valid: 1'b1, op: w_reqOp[p]};
        end else if (w_grant[p]) begin
          r_slot[p].valid <= 1'b0;
        end
        if (w_grant[p]) begin
          r_score[p] <= apply_op(r_score[p], r_slot[p].op);
        end
      end
      if (w_update) r_favorB <= w_grant[0];
      if (|w_drop) r_overflow <= 1'b1;
    end
  end

  display_scheduler #(
    .SWAP_TICKS(SWAP_TICKS),
    .HOLD_TICKS(HOLD_TICKS)
  ) u_sched (
    .i_clk       (clk_1khz_i),
    .i_rstN      (rst_n_i),
    .i_update    (w_update),
    .i_updPlayer (w_grant[1]),
    .o_dispSel   (w_dispSel)
  );

  assign score_a_o    = r_score[0];
  assign score_b_o    = r_score[1];
  assign disp_sel_o   = w_dispSel;
  assign disp_score_o = w_dispSel ? r_score[1] : r_score[0];
  assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_score_arbiter.sv
// Directed self-checking bench for score_arbiter: rotation timing, counting,
// tie arbitration, saturation, request dropping and mid-operation reset.
module tb_score_arbiter;
  import scoreboard_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               upA;
  logic               downA;
  logic               upB;
  logic               downB;
  logic [SCORE_W-1:0] scoreA;
  logic [SCORE_W-1:0] scoreB;
  logic [SCORE_W-1:0] dispScore;
  logic               dispSel;
  logic               overflow;

  int checks = 0;
  int errors = 0;

  score_arbiter #(
    .SWAP_TICKS(2000),
    .HOLD_TICKS(3000)
  ) dut (
    .clk_1khz_i   (clk),
    .rst_n_i      (rst_n),
    .up_a_i       (upA),
    .down_a_i     (downA),
    .up_b_i       (upB),
    .down_b_i     (downB),
    .score_a_o    (scoreA),
    .score_b_o    (scoreB),
    .disp_score_o (dispScore),
    .disp_sel_o   (dispSel),
    .overflow_o   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    upA = 1'b0; downA = 1'b0; upB = 1'b0; downB = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    waitCycles(1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    upA = 1'b0; downA = 1'b0; upB = 1'b0; downB = 1'b0;
    waitCycles(2);
    checks++; if (scoreA !== 7'd0) begin errors++; $display("[TB] FAIL reset_scoreA got %0d want 0", scoreA); end
    checks++; if (scoreB !== 7'd0) begin errors++; $display("[TB] FAIL reset_scoreB got %0d want 0", scoreB); end
    checks++; if (dispScore !== 7'd0) begin errors++; $display("[TB] FAIL reset_dispScore got %0d want 0", dispScore); end
    checks++; if (dispSel !== 1'b0) begin errors++; $display("[TB] FAIL reset_dispSel got %b want 0", dispSel); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b want 0", overflow); end
    rst_n = 1'b1;
  endtask

  task automatic test_rotate();
    doReset();
    waitCycles(1999);
    checks++; if (dispSel !== 1'b0) begin errors++; $display("[TB] FAIL rotate_before1 got %b want 0", dispSel); end
    waitCycles(1);
    checks++; if (dispSel !== 1'b1) begin errors++; $display("[TB] FAIL rotate_toB got %b want 1", dispSel); end
    waitCycles(1999);
    checks++; if (dispSel !== 1'b1) begin errors++; $display("[TB] FAIL rotate_before2 got %b want 1", dispSel); end
    waitCycles(1);
    checks++; if (dispSel !== 1'b0) begin errors++; $display("[TB] FAIL rotate_toA got %b want 0", dispSel); end
    checks++; if (scoreA !== 7'd0 || scoreB !== 7'd0) begin errors++; $display("[TB] FAIL rotate_scores got %0d/%0d want 0/0", scoreA, scoreB); end
  endtask

  task automatic test_count_up();
    doReset();
    for (int i = 0; i < 3; i++) begin
      upA = 1'b1;
      waitCycles(1);
      upA = 1'b0;
      checks++; if (scoreA !== 7'(i)) begin errors++; $display("[TB] FAIL count_capture got %0d want %0d", scoreA, i); end
      waitCycles(1);
      checks++; if (scoreA !== 7'(i + 1)) begin errors++; $display("[TB] FAIL count_step got %0d want %0d", scoreA, i + 1); end
      waitCycles(3);
    end
    checks++; if (dispSel !== 1'b0) begin errors++; $display("[TB] FAIL count_dispSel got %b want 0", dispSel); end
    checks++; if (dut.u_sched.r_state !== ST_HOLD) begin errors++; $display("[TB] FAIL count_state got %0d want %0d", dut.u_sched.r_state, ST_HOLD); end
    checks++; if (dispScore !== 7'd3) begin errors++; $display("[TB] FAIL count_dispScore got %0d want 3", dispScore); end
  endtask

  task automatic test_tie();
    doReset();
    upA = 1'b1; upB = 1'b1;
    waitCycles(1);
    upA = 1'b0; upB = 1'b0;
    checks++; if (scoreA !== 7'd0 || scoreB !== 7'd0) begin errors++; $display("[TB] FAIL tie_capture got %0d/%0d want 0/0", scoreA, scoreB); end
    waitCycles(1);
    checks++; if (scoreA !== 7'd1 || scoreB !== 7'd0) begin errors++; $display("[TB] FAIL tie_firstA got %0d/%0d want 1/0", scoreA, scoreB); end
    waitCycles(1);
    checks++; if (scoreB !== 7'd1) begin errors++; $display("[TB] FAIL tie_thenB got %0d want 1", scoreB); end
    checks++; if (dispSel !== 1'b1) begin errors++; $display("[TB] FAIL tie_dispSel got %b want 1", dispSel); end
    checks++; if (dispScore !== 7'd1) begin errors++; $display("[TB] FAIL tie_dispScore got %0d want 1", dispScore); end
  endtask

  task automatic test_saturate();
    doReset();
    downB = 1'b1;
    waitCycles(1);
    downB = 1'b0;
    waitCycles(1);
    checks++; if (scoreB !== 7'd0) begin errors++; $display("[TB] FAIL sat_zero got %0d want 0", scoreB); end
    checks++; if (dispSel !== 1'b1) begin errors++; $display("[TB] FAIL sat_holdSel got %b want 1", dispSel); end
    waitCycles(2999);
    checks++; if (dut.u_sched.r_state !== ST_HOLD || dispSel !== 1'b1) begin errors++; $display("[TB] FAIL sat_holdEnd got state %0d sel %b want 1/1", dut.u_sched.r_state, dispSel); end
    waitCycles(1);
    checks++; if (dut.u_sched.r_state !== ST_ROTATE || dispSel !== 1'b1) begin errors++; $display("[TB] FAIL sat_toRotate got state %0d sel %b want 0/1", dut.u_sched.r_state, dispSel); end
    for (int i = 0; i < 99; i++) begin
      upA = 1'b1;
      waitCycles(1);
      upA = 1'b0;
      waitCycles(1);
    end
    checks++; if (scoreA !== 7'd99) begin errors++; $display("[TB] FAIL sat_reach99 got %0d want 99", scoreA); end
    upA = 1'b1;
    waitCycles(1);
    upA = 1'b0;
    waitCycles(2);
    checks++; if (scoreA !== 7'd99) begin errors++; $display("[TB] FAIL sat_max got %0d want 99", scoreA); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL sat_overflow got %b want 0", overflow); end
    checks++; if (dispSel !== 1'b0 || dispScore !== 7'd99) begin errors++; $display("[TB] FAIL sat_disp got sel %b score %0d want 0/99", dispSel, dispScore); end
  endtask

  task automatic test_back_to_back();
    doReset();
    upA = 1'b1;
    waitCycles(2);
    upA = 1'b0;
    checks++; if (scoreA !== 7'd1) begin errors++; $display("[TB] FAIL b2b_first got %0d want 1", scoreA); end
    waitCycles(1);
    checks++; if (scoreA !== 7'd2) begin errors++; $display("[TB] FAIL b2b_second got %0d want 2", scoreA); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overflow got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    doReset();
    upA = 1'b1;
    waitCycles(1);
    upA = 1'b0;
    waitCycles(3);
    upA = 1'b1; upB = 1'b1;
    waitCycles(1);
    upB = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early got %b want 0", overflow); end
    waitCycles(1);
    upA = 1'b0;
    checks++; if (scoreB !== 7'd1 || scoreA !== 7'd1) begin errors++; $display("[TB] FAIL ovf_Bwins got %0d/%0d want 1/1", scoreA, scoreB); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got %b want 1", overflow); end
    checks++; if (dispSel !== 1'b1) begin errors++; $display("[TB] FAIL ovf_selB got %b want 1", dispSel); end
    waitCycles(1);
    checks++; if (scoreA !== 7'd2 || dispSel !== 1'b0) begin errors++; $display("[TB] FAIL ovf_Alater got %0d sel %b want 2/0", scoreA, dispSel); end
    waitCycles(3);
    checks++; if (scoreA !== 7'd2 || overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %0d ovf %b want 2/1", scoreA, overflow); end
    upA = 1'b1; downA = 1'b1;
    waitCycles(1);
    upA = 1'b0; downA = 1'b0;
    waitCycles(3);
    checks++; if (scoreA !== 7'd2 || dispSel !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cancel got %0d sel %b want 2/0", scoreA, dispSel); end
  endtask

  task automatic test_mid_reset();
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL mid_preOvf got %b want 1", overflow); end
    upA = 1'b1;
    waitCycles(1);
    upA = 1'b0;
    waitCycles(1);
    checks++; if (scoreA !== 7'd3 || dut.u_sched.r_state !== ST_HOLD) begin errors++; $display("[TB] FAIL mid_pre got %0d state %0d want 3/1", scoreA, dut.u_sched.r_state); end
    upB = 1'b1;
    waitCycles(1);
    upB = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (scoreA !== 7'd0 || scoreB !== 7'd0 || dispScore !== 7'd0) begin errors++; $display("[TB] FAIL mid_scores got %0d/%0d/%0d want 0/0/0", scoreA, scoreB, dispScore); end
    checks++; if (dispSel !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL mid_flags got sel %b ovf %b want 0/0", dispSel, overflow); end
    waitCycles(1);
    rst_n = 1'b1;
    waitCycles(5);
    checks++; if (scoreA !== 7'd0 || scoreB !== 7'd0) begin errors++; $display("[TB] FAIL mid_late got %0d/%0d want 0/0", scoreA, scoreB); end
    checks++; if (dut.u_sched.r_state !== ST_ROTATE || dispSel !== 1'b0) begin errors++; $display("[TB] FAIL mid_state got %0d sel %b want 0/0", dut.u_sched.r_state, dispSel); end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_count_up();
    test_tie();
    test_saturate();
    test_back_to_back();
    test_overflow();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
